// File: rtl/m_mem_access_unit_pkg.sv
// Shared definitions for the M-stage memory access unit.
//   - mem_type_e : access size encoding carried on MMemType (11 is reserved and behaves as word)
//   - state_e    : bus FSM states
//   - TIMEOUT_DEFAULT / CNT_W_DEFAULT : default wait-counter configuration
//   - is_misaligned() : alignment rule used when MISALIGN_CHECK_EN is defined
package m_mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10,
    MEM_RSVD = 2'b11
  } mem_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W_DEFAULT   = 8;

  // Word (and reserved) accesses need addr[1:0]==0, halves need addr[0]==0.
  function automatic logic is_misaligned(input mem_type_e t, input logic [1:0] a);
    case (t)
      MEM_HALF: return a[0];
      MEM_BYTE: return 1'b0;
      default:  return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/m_mem_access_unit_lane.sv
// m_mem_lane: purely combinational lane logic for one access.
//   i_type     access size           o_byte_en  bus lane enables
//   i_addr_lo  byte offset addr[1:0] o_wdata    store data replicated across lanes
//   i_signed   sign-extend loads     o_rdata    selected and extended load data
//   i_wdata    raw store data (rt)
//   i_rdata    raw bus read word
// Lanes are little-endian: byte 0 of the word is bits [7:0].
module m_mem_lane
  import m_mem_access_unit_pkg::*;
(
  input  mem_type_e   i_type,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // NOTE: every output gets a default before the case so no path leaves a value unassigned (no latch).
  always_comb begin
    o_byte_en = 4'b1111;
    o_wdata   = i_wdata;
    o_rdata   = i_rdata;
    w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_byte    = i_rdata[{i_addr_lo, 3'b000} +: 8];
    case (i_type)
      MEM_HALF: begin
        // addr[0] is ignored: a half always sits on lanes 1:0 or 3:2.
        o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_wdata[15:0]}};
        o_rdata   = {{16{i_signed & w_half[15]}}, w_half};
      end
      MEM_BYTE: begin
        o_byte_en = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        o_rdata   = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      default: ; // word and reserved: full word, address low bits ignored
    endcase
  end

endmodule

// File: rtl/m_mem_access_unit.sv
// m_mem_access_unit: M-stage data-memory access. Turns the E->M register contents into one
// req/ack bus transaction, stalls the pipeline until it completes, and returns aligned load data.
// Ports:
//   Clk, Reset (synchronous, active-high)
//   MValid/MMemRead/MMemWrite/MMemType/MLoadSigned/MAddr/MWData : M-register instruction fields
//   StallM                 : freeze upstream registers this cycle
//   MemRdData/MemRdValid   : load result, one-cycle valid in DONE
//   BusReq/BusWe/BusAddr/BusByteEn/BusWData : request side, held until BusAck
//   BusAck/BusRData        : completion and read word
//   BusTimeout             : one-cycle pulse (in DONE) when the access was forced complete
// Configuration: define MISALIGN_CHECK_EN to add ExcAdEL/ExcAdES and reject misaligned word/half
// accesses; otherwise low address bits below the access size are ignored.
// TIMEOUT must be < 2**CNT_W; TIMEOUT == 0 disables the forced completion.
module m_mem_access_unit
  import m_mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MValid,
  input  logic        MMemRead,
  input  logic        MMemWrite,
  input  logic [1:0]  MMemType,
  input  logic        MLoadSigned,
  input  logic [31:0] MAddr,
  input  logic [31:0] MWData,
  output logic        StallM,
  output logic [31:0] MemRdData,
  output logic        MemRdValid,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusByteEn,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic [31:0] BusRData,
  output logic        BusTimeout
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        ExcAdEL,
  output logic        ExcAdES
`endif
);

  state_e           r_state;
  logic             r_bus_req;
  logic             r_we;
  logic             r_signed;
  mem_type_e        r_type;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rd_data;
  logic             r_rd_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_wait_cnt;

  logic        w_access;
  logic        w_misalign;
  logic        w_access_ok;
  logic        w_timeout_hit;
  logic [3:0]  w_lane_be;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;

  assign w_access = MValid & (MMemRead | MMemWrite);

`ifdef MISALIGN_CHECK_EN
  assign w_misalign = w_access & is_misaligned(mem_type_e'(MMemType), MAddr[1:0]);
  // A MemRead+MemWrite instruction is a store, so it reports the store exception.
  assign ExcAdEL = (r_state == ST_IDLE) & w_misalign & ~MMemWrite;
  assign ExcAdES = (r_state == ST_IDLE) & w_misalign &  MMemWrite;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_access_ok   = w_access & ~w_misalign;
  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TIMEOUT));

  // Lane logic works from the latched copy so bus outputs stay stable while M is frozen.
  m_mem_lane u_lane (
    .i_type    (r_type),
    .i_addr_lo (r_addr[1:0]),
    .i_signed  (r_signed),
    .i_wdata   (r_wdata),
    .i_rdata   (BusRData),
    .o_byte_en (w_lane_be),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_lane_rdata)
  );

  // NOTE: StallM is combinational so the hazard is seen in the same cycle the access is detected;
  // a registered stall would let the pipeline advance past the instruction once.
  assign StallM = (r_state == ST_BUSY) | ((r_state == ST_IDLE) & w_access_ok);

  assign BusReq     = r_bus_req;
  assign BusWe      = r_bus_req & r_we;
  assign BusAddr    = r_bus_req ? {r_addr[31:2], 2'b00} : '0;
  assign BusByteEn  = r_bus_req ? w_lane_be : '0;
  assign BusWData   = r_bus_req ? w_lane_wdata : '0;
  assign MemRdData  = r_rd_data;
  assign MemRdValid = r_rd_valid;
  assign BusTimeout = r_timeout;

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_bus_req  <= 1'b0;
      r_we       <= 1'b0;
      r_signed   <= 1'b0;
      r_type     <= MEM_WORD;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rd_valid <= 1'b0;
          r_timeout  <= 1'b0;
          if (w_access_ok) begin
            r_type    <= mem_type_e'(MMemType);
            r_we      <= MMemWrite;
            r_signed  <= MLoadSigned;
            r_addr    <= MAddr;
            r_wdata   <= MWData;
            r_bus_req <= 1'b1;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          // A real ack in the last allowed cycle wins over the timeout.
          if (BusAck) begin
            r_rd_data  <= w_lane_rdata;
            r_rd_valid <= ~r_we;
            r_bus_req  <= 1'b0;
            r_state    <= ST_DONE;
          end else if (w_timeout_hit) begin
            r_rd_data  <= '0;
            r_rd_valid <= ~r_we;
            r_timeout  <= 1'b1;
            r_bus_req  <= 1'b0;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_rd_valid <= 1'b0;
          r_timeout  <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_access_unit.sv
// Scoreboard bench for m_mem_access_unit. The stimulus process acts as the pipeline (advances the
// M instruction only on a cycle with StallM low) and pushes the model's expected transaction;
// a bus responder acks after a chosen delay; a monitor compares every cycle against the queue head.
module tb_m_mem_access_unit;

  localparam int TB_TIMEOUT = 4;
  localparam int NEVER      = 1000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MValid, MMemRead, MMemWrite, MLoadSigned;
  logic [1:0]  MMemType;
  logic [31:0] MAddr, MWData;
  logic        StallM, MemRdValid, BusReq, BusWe, BusAck, BusTimeout;
  logic [31:0] MemRdData, BusAddr, BusWData, BusRData;
  logic [3:0]  BusByteEn;
`ifdef MISALIGN_CHECK_EN
  logic        ExcAdEL, ExcAdES;
`endif

  m_mem_access_unit #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .MValid(MValid), .MMemRead(MMemRead), .MMemWrite(MMemWrite),
    .MMemType(MMemType), .MLoadSigned(MLoadSigned), .MAddr(MAddr), .MWData(MWData),
    .StallM(StallM), .MemRdData(MemRdData), .MemRdValid(MemRdValid), .BusReq(BusReq),
    .BusWe(BusWe), .BusAddr(BusAddr), .BusByteEn(BusByteEn), .BusWData(BusWData),
    .BusAck(BusAck), .BusRData(BusRData), .BusTimeout(BusTimeout)
`ifdef MISALIGN_CHECK_EN
    , .ExcAdEL(ExcAdEL), .ExcAdES(ExcAdES)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          we;
    bit          load;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    bit          timeout;
    int          busy;
    int          stall;
    bit          exc;
    bit          exc_l;
    bit          exc_s;
  } exp_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
  } cfg_t;

  exp_t exp_q[$];
  cfg_t cfg_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: access size in bytes, lane offset, masks and shifts.
  function automatic exp_t model(bit wr, logic [1:0] typ, bit sgn, logic [31:0] addr,
                                 logic [31:0] wd, logic [31:0] rdata, int delay);
    exp_t        e;
    int          size;
    int          off;
    logic [31:0] mask;
    logic [31:0] val;
    size = (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
    e.we    = wr;
    e.load  = !wr;
    e.exc   = 1'b0;
`ifdef MISALIGN_CHECK_EN
    e.exc   = (size == 4 && addr[1:0] != 2'b00) || (size == 2 && addr[0]);
`endif
    e.exc_l = e.exc && !wr;
    e.exc_s = e.exc && wr;
    off     = (size == 4) ? 0 : (size == 2) ? (addr[1] ? 2 : 0) : int'(addr[1:0]);
    e.addr  = addr & ~32'h3;
    e.be    = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    val  = (rdata >> (8 * off)) & mask;
    if (sgn && size < 4 && val[8*size-1]) val = val | ~mask;
    e.timeout = delay > TB_TIMEOUT;
    e.busy    = e.timeout ? TB_TIMEOUT + 1 : delay + 1;
    e.stall   = e.busy + 1;
    e.rd_data = e.timeout ? 32'h0 : val;
    return e;
  endfunction

  // Present one M instruction and hold it until the pipeline advances past it.
  task automatic issue(bit valid, bit rd, bit wr, logic [1:0] typ, bit sgn, logic [31:0] addr,
                       logic [31:0] wd, logic [31:0] rdata, int delay);
    exp_t e;
    cfg_t c;
    logic s;
    MValid = valid; MMemRead = rd; MMemWrite = wr; MMemType = typ;
    MLoadSigned = sgn; MAddr = addr; MWData = wd;
    if (valid && (rd || wr)) begin
      e = model(wr, typ, sgn, addr, wd, rdata, delay);
      exp_q.push_back(e);
      if (!e.exc) begin
        c.delay = delay; c.rdata = rdata;
        cfg_q.push_back(c);
      end
    end
    s = 1'b1;
    for (int k = 0; k < 64 && s; k++) begin
      @(negedge Clk);
      s = StallM;
      @(posedge Clk);
      #1;
    end
    if (s) check("pipeline_advance", s, 1'b0);
  endtask

  // Bus responder: ack after the configured number of BUSY cycles, random spurious acks when idle.
  int   rsp_k;
  bit   rsp_active = 1'b0;
  cfg_t rsp_cur;
  always @(negedge Clk) begin
    if (Reset || !BusReq) begin
      rsp_active = 1'b0;
      BusAck     = ($urandom_range(0, 7) == 0);
      BusRData   = $urandom;
    end else begin
      if (!rsp_active) begin
        rsp_active = 1'b1;
        rsp_k      = 0;
        if (cfg_q.size() > 0) rsp_cur = cfg_q.pop_front();
        else begin rsp_cur.delay = NEVER; rsp_cur.rdata = '0; end
      end else rsp_k++;
      BusAck   = (rsp_k == rsp_cur.delay);
      BusRData = BusAck ? rsp_cur.rdata : $urandom;
    end
  end

  // Monitor: compares DUT behaviour each cycle against the head of the expected queue.
  int stall_cnt = 0;
  int req_cnt   = 0;
  always @(negedge Clk) begin : mon
    exp_t e;
    if (mon_en && !Reset) begin
      if (exp_q.size() == 0) begin
        check("quiet", {StallM, BusReq, MemRdValid, BusTimeout}, 4'b0);
      end else begin
        e = exp_q[0];
        if (e.exc) begin
`ifdef MISALIGN_CHECK_EN
          check("misalign_exc", {StallM, BusReq, ExcAdEL, ExcAdES}, {2'b00, e.exc_l, e.exc_s});
`endif
          void'(exp_q.pop_front());
        end else if (StallM) begin
          stall_cnt++;
          check("stall_pulses", {MemRdValid, BusTimeout}, 2'b00);
          if (BusReq) begin
            req_cnt++;
            check("bus_fields", {BusWe, BusAddr, BusByteEn, BusWData}, {e.we, e.addr, e.be, e.wdata});
          end
        end else if (stall_cnt == 0) begin
          check("stall_on_access", StallM, 1'b1);
          void'(exp_q.pop_front());
        end else begin
          check("stall_cycles", stall_cnt, e.stall);
          check("req_cycles", req_cnt, e.busy);
          check("done_busreq", BusReq, 1'b0);
          check("rd_valid", MemRdValid, e.load);
          if (e.load) check("rd_data", MemRdData, e.rd_data);
          check("bus_timeout", BusTimeout, e.timeout);
          void'(exp_q.pop_front());
          stall_cnt = 0;
          req_cnt   = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; MValid = 1'b0; MMemRead = 1'b0; MMemWrite = 1'b0; MMemType = 2'b00;
    MLoadSigned = 1'b0; MAddr = '0; MWData = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_outputs", {StallM, BusReq, BusWe, BusAddr, BusByteEn, BusWData,
                            MemRdValid, MemRdData, BusTimeout}, '0);
    @(posedge Clk); #1;
    Reset  = 1'b0;
    mon_en = 1'b1;

    // Directed vectors.
    issue(1, 0, 1, 2'b00, 0, 32'h10, 32'h1234_5678, 32'h0, 0);          // sw, ack first cycle
    issue(1, 1, 0, 2'b10, 1, 32'h13, 32'h0, 32'h80FF_FFFF, 0);          // lb  -> FFFFFF80
    issue(1, 1, 0, 2'b10, 0, 32'h13, 32'h0, 32'h80FF_FFFF, 1);          // lbu -> 00000080
    issue(1, 0, 1, 2'b01, 0, 32'h22, 32'h0000_ABCD, 32'h0, 2);          // sh  -> ABCDABCD, 1100
    issue(1, 1, 0, 2'b00, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 4);         // ack in 5th BUSY cycle
    issue(1, 1, 0, 2'b00, 0, 32'h104, 32'h0, 32'hCAFE_F00D, 5);         // one past timeout
    issue(1, 1, 0, 2'b01, 1, 32'h108, 32'h0, 32'h1234_8765, NEVER);     // never acked
    issue(1, 1, 1, 2'b10, 0, 32'h201, 32'h0000_00A5, 32'h0, 1);         // read+write is a write
    issue(0, 1, 0, 2'b00, 0, 32'h300, 32'h0, 32'h0, 0);                 // bubble
    issue(1, 0, 0, 2'b00, 0, 32'h300, 32'h0, 32'h0, 0);                 // no memory op
    issue(1, 1, 0, 2'b11, 1, 32'h40, 32'h0, 32'h8000_0001, 0);          // reserved type = word
    issue(1, 1, 0, 2'b01, 1, 32'h42, 32'h0, 32'h9ABC_0000, 0);          // lh upper half
    issue(1, 0, 1, 2'b00, 0, 32'h02, 32'h5555_AAAA, 32'h0, 0);          // misaligned sw
    issue(1, 1, 0, 2'b00, 0, 32'h02, 32'h0, 32'h1111_2222, 0);          // misaligned lw

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      issue($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, (r <= 6) ? r : NEVER);
    end

    check("queue_drained", exp_q.size(), 0);

    // Reset while BUSY drops BusReq on the next edge.
    mon_en = 1'b0;
    MValid = 1'b1; MMemRead = 1'b1; MMemWrite = 1'b0; MMemType = 2'b00; MAddr = 32'h400;
    cfg_q.push_back('{delay: NEVER, rdata: 32'h0});
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("busreq_in_busy", BusReq, 1'b1);
    @(posedge Clk); #1;
    Reset = 1'b1; MValid = 1'b0;
    @(negedge Clk);
    check("busreq_before_reset_edge", BusReq, 1'b1);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("reset_in_busy", {StallM, BusReq, BusWe, BusByteEn, MemRdValid, BusTimeout}, '0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    cfg_q.delete();
    exp_q.delete();
    repeat (2) @(posedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
